data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised, handshaked data memory for the pipelined RISC-V MEM stage.
- Byte-addressed, little-endian word array.
- Supports byte, half and word loads and stores, with sign or zero extension on loads.
- Has configurable access latency, a one-cycle response strobe and misalignment detection; the pipeline stalls on req_ready.

Parameters:
- ADDR_WIDTH, 8, byte-address width; array depth is 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, cycles from request accept to the memory access edge; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  input  1  load zero-extends (LBU/LHU) when 1, sign-extends when 0
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data; byte/half taken from the low bits
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  extended load data; 0 for stores and faults
- rsp_misaligned  output  1  request faulted; valid only with rsp_valid

Behaviour:
- Reset: async assert forces state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_misaligned 0.
- After release, req_ready is 1 from the first clk edge onward.
- Memory array is not cleared by reset.
- States and transitions:
  - IDLE: req_ready = 1. Request is accepted on a clk edge with req_valid && req_ready; the block latches write, size, unsigned, addr and wdata.
  - IDLE on accept: if misaligned, go to RESP. Otherwise go to WAIT with counter = LATENCY-1.
  - WAIT: req_ready = 0. Counter decrements each edge. On the edge where the counter is 0, the access is performed and the state goes to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0. Next edge returns to IDLE.
- No back-to-back acceptance: minimum spacing between accepts is LATENCY+2 cycles.
- Misaligned cases:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - any request with size 11
- On misalignment: no memory write, rsp_misaligned = 1, rsp_rdata = 0, and the response is asserted in the cycle after accept.
- Word index is addr[ADDR_WIDTH-1:2]; lane k = addr[1:0] maps to bits [8k+7:8k].
- Store:
  - byte writes only lane k;
  - half writes lanes addr[1] ? 3:2 : 1:0;
  - word writes all lanes.
  - Other lanes are preserved (read-modify-write within the same edge).
  - rsp_rdata = 0, rsp_misaligned = 0.
- Load:
  - Selects the lane(s) above.
  - Extends to 32 bits: sign-extends from bit 7 or bit 15 unless req_unsigned; word is unmodified.
  - Data is registered into rsp_rdata on the access edge and held only while rsp_valid; rsp_rdata returns to 0 after RESP.
- Latency: accept edge N, access edge N+LATENCY, rsp_valid high during cycle after edge N+LATENCY, req_ready high again after edge N+LATENCY+1.
- Inputs other than req_valid are don't-care outside the accept edge; request fields are latched, so changes during WAIT have no effect.
- Reset mid-operation: an outstanding request is dropped, no response is issued, and a store whose access edge has not occurred leaves memory unchanged.
- All addresses within ADDR_WIDTH are valid; there is no out-of-range fault.

Test Plan:
- Word store then load, LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid exactly 3 cycles after each accept edge, rsp_rdata = 0xDEADBEEF, rsp_misaligned = 0.
- Byte lanes: SW 0x11223344 @0x20; SB 0xAA @0x22; LW @0x20 -> 0x11AA3344; LB @0x22 -> 0xFFFFFFAA; LBU @0x22 -> 0x000000AA.
- Half extension: SH 0x8001 @0x32; LH @0x32 -> 0xFFFF8001; LHU @0x32 -> 0x00008001; LW @0x30 -> upper half 0x8001, lower half unchanged.
- Misalignment:
  - LW @0x21 -> rsp_valid 1 cycle after accept, rsp_misaligned = 1, rsp_rdata = 0.
  - SH @0x23 -> same fault; a following LW @0x20 shows the word unchanged.
  - size 11 -> same fault response.
- Handshake: hold req_valid high continuously -> req_ready low in WAIT/RESP; accepts spaced exactly LATENCY+2 cycles; no duplicate responses; sweep LATENCY = 1, 4, 8.
- Reset mid-store: SW 0x55555555 @0x40 over 0x12345678 (LATENCY=4), pulse rst_n low in the 2nd WAIT cycle -> no rsp_valid, outputs 0 during reset, LW @0x40 afterwards -> 0x12345678.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM pipeline stage and data_mem_ctrl.
// The master drives requests, and the slave returns a one-cycle response strobe.
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_misaligned;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressed little-endian data memory for the RISC-V MEM stage.
// Supports a configurable access latency, byte/half/word stores and sign/zero-extended loads.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned DEPTH    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mis_q, mis_d;

  logic [31:0]           mem_q [DEPTH];

  logic                  accept;
  logic                  req_mis;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] widx;
  logic [3:0]            be;
  logic [31:0]           bmask;
  logic [31:0]           wword;
  logic [31:0]           rword;
  logic [7:0]            lbyte;
  logic [15:0]           lhalf;
  logic [31:0]           load_data;

  assign accept = bus.req_valid && ready_q && (state_q == IDLE);

  always_comb begin
    req_mis = 1'b0;
    case (bus.req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = bus.req_addr[0];
      2'b10:   req_mis = (bus.req_addr[1:0] != 2'b00);
      default: req_mis = 1'b1;
    endcase
  end

  assign widx   = addr_q[ADDR_WIDTH-1:2];
  assign rword  = mem_q[widx];
  assign mem_we = (state_q == WAIT) && (cnt_q == 4'd0) && wr_q;

  // Replicating the store data across lanes lets the byte enables alone pick the target lanes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
      default: begin
        be    = 4'b0000;
        wword = wdata_q;
      end
    endcase
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_comb begin
    lbyte = rword[7:0];
    case (addr_q[1:0])
      2'b00: lbyte = rword[7:0];
      2'b01: lbyte = rword[15:8];
      2'b10: lbyte = rword[23:16];
      2'b11: lbyte = rword[31:24];
      default: lbyte = rword[7:0];
    endcase
    lhalf     = addr_q[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    case (size_q)
      2'b00:   load_data = {{24{lbyte[7] & ~uns_q}}, lbyte};
      2'b01:   load_data = {{16{lhalf[15] & ~uns_q}}, lhalf};
      default: load_data = rword;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = '0;
    mis_d       = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          wr_d    = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          ready_d = 1'b0;
          if (req_mis) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            mis_d       = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? '0 : load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values, so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
    end
  end

  // The array is never cleared. A reset forces IDLE asynchronously, which blocks any pending write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx] <= (rword & ~bmask) | (wword & bmask);
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_misaligned = mis_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl at LATENCY 1, 2, 4 and 8.
// Requests go to one selected instance, and the bench compares each response with a queued expectation.
module tb_data_mem_ctrl;
  logic        clk;
  logic        rst_n;
  int unsigned sel;

  logic        t_valid;
  logic        t_write;
  logic [1:0]  t_size;
  logic        t_uns;
  logic [7:0]  t_addr;
  logic [31:0] t_wdata;

  logic        m_ready;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        m_mis;

  int checks;
  int errors;
  int lats [4];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;
  exp_t sb [$];

  data_mem_ctrl_if #(.ADDR_WIDTH(8)) b0 ();
  data_mem_ctrl_if #(.ADDR_WIDTH(8)) b1 ();
  data_mem_ctrl_if #(.ADDR_WIDTH(8)) b2 ();
  data_mem_ctrl_if #(.ADDR_WIDTH(8)) b3 ();

  data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut_l1 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut_l2 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(4)) u_dut_l4 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(8)) u_dut_l8 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  assign b0.req_valid = t_valid && (sel == 0);
  assign b1.req_valid = t_valid && (sel == 1);
  assign b2.req_valid = t_valid && (sel == 2);
  assign b3.req_valid = t_valid && (sel == 3);
  assign b0.req_write = t_write;  assign b1.req_write = t_write;
  assign b2.req_write = t_write;  assign b3.req_write = t_write;
  assign b0.req_size  = t_size;   assign b1.req_size  = t_size;
  assign b2.req_size  = t_size;   assign b3.req_size  = t_size;
  assign b0.req_unsigned = t_uns; assign b1.req_unsigned = t_uns;
  assign b2.req_unsigned = t_uns; assign b3.req_unsigned = t_uns;
  assign b0.req_addr  = t_addr;   assign b1.req_addr  = t_addr;
  assign b2.req_addr  = t_addr;   assign b3.req_addr  = t_addr;
  assign b0.req_wdata = t_wdata;  assign b1.req_wdata = t_wdata;
  assign b2.req_wdata = t_wdata;  assign b3.req_wdata = t_wdata;

  always_comb begin
    case (sel)
      0: begin m_ready = b0.req_ready; m_rsp_valid = b0.rsp_valid; m_rsp_rdata = b0.rsp_rdata; m_mis = b0.rsp_misaligned; end
      1: begin m_ready = b1.req_ready; m_rsp_valid = b1.rsp_valid; m_rsp_rdata = b1.rsp_rdata; m_mis = b1.rsp_misaligned; end
      2: begin m_ready = b2.req_ready; m_rsp_valid = b2.rsp_valid; m_rsp_rdata = b2.rsp_rdata; m_mis = b2.rsp_misaligned; end
      default: begin m_ready = b3.req_ready; m_rsp_valid = b3.rsp_valid; m_rsp_rdata = b3.rsp_rdata; m_mis = b3.rsp_misaligned; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and check its response. lat is the number of edges after the accept edge before rsp_valid is seen.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic em);
    exp_t e;
    int   k;
    e.rdata = er;
    e.mis   = em;
    e.lat   = em ? 0 : lats[sel];
    sb.push_back(e);
    k = 0;
    while (!m_ready && k < 40) begin @(negedge clk); k++; end
    chk({tag, "/ready"}, 32'(m_ready), 32'd1);
    t_write = w; t_size = sz; t_uns = u; t_addr = a; t_wdata = wd;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    t_write = 1'($urandom); t_size = 2'($urandom); t_uns = 1'($urandom);
    t_addr  = 8'($urandom); t_wdata = $urandom;
    k = 0;
    while (!m_rsp_valid && k < 20) begin @(negedge clk); k++; end
    e = sb.pop_front();
    chk({tag, "/rsp_valid"}, 32'(m_rsp_valid), 32'd1);
    chk({tag, "/latency"}, 32'(k), 32'(e.lat));
    chk({tag, "/rdata"}, m_rsp_rdata, e.rdata);
    chk({tag, "/misaligned"}, 32'(m_mis), 32'(e.mis));
    @(negedge clk);
    chk({tag, "/one_shot"}, 32'(m_rsp_valid), 32'd0);
    chk({tag, "/rdata_clear"}, m_rsp_rdata, 32'd0);
    chk({tag, "/ready_back"}, 32'(m_ready), 32'd1);
  endtask

  // Hold req_valid high, record when accepts happen, and count the responses.
  task automatic hold_test(input string tag);
    int acc [$];
    int rsp_n;
    int L;
    L     = lats[sel];
    rsp_n = 0;
    t_write = 1'b0; t_size = 2'b10; t_uns = 1'b0; t_addr = 8'h10; t_wdata = '0;
    t_valid = 1'b1;
    for (int c = 0; c < 3 * (L + 2); c++) begin
      if (m_ready) acc.push_back(c);
      if (m_rsp_valid) rsp_n++;
      @(negedge clk);
    end
    t_valid = 1'b0;
    for (int c = 0; c < L + 3; c++) begin
      if (m_rsp_valid) rsp_n++;
      @(negedge clk);
    end
    chk({tag, "/accepts"}, 32'(acc.size()), 32'd3);
    for (int i = 1; i < acc.size(); i++)
      chk({tag, "/spacing"}, 32'(acc[i] - acc[i-1]), 32'(L + 2));
    chk({tag, "/responses"}, 32'(rsp_n), 32'd3);
  endtask

  initial begin
    int k;
    checks = 0;
    errors = 0;
    lats   = '{1, 2, 4, 8};
    sel    = 1;
    rst_n  = 1'b0;
    t_valid = 1'b0; t_write = 1'b0; t_size = '0; t_uns = 1'b0; t_addr = '0; t_wdata = '0;

    repeat (2) @(negedge clk);
    chk("reset/ready", 32'(m_ready), 32'd0);
    chk("reset/rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("reset/rdata", m_rsp_rdata, 32'd0);
    chk("reset/mis", 32'(m_mis), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release/ready_pre_edge", 32'(m_ready), 32'd0);
    @(negedge clk);
    chk("release/ready_first_edge", 32'(m_ready), 32'd1);

    // Tests at LATENCY 2.
    txn("sw_10",   1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    txn("lw_10",   1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    txn("sw_20",   1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, 32'h0,        1'b0);
    txn("sb_22",   1'b1, 2'b00, 1'b0, 8'h22, 32'h123456AA, 32'h0,        1'b0);
    txn("lw_20",   1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'h11AA3344, 1'b0);
    txn("lb_22",   1'b0, 2'b00, 1'b0, 8'h22, 32'h0,        32'hFFFFFFAA, 1'b0);
    txn("lbu_22",  1'b0, 2'b00, 1'b1, 8'h22, 32'h0,        32'h000000AA, 1'b0);
    txn("lb_23",   1'b0, 2'b00, 1'b0, 8'h23, 32'h0,        32'h00000011, 1'b0);
    txn("sw_30",   1'b1, 2'b10, 1'b0, 8'h30, 32'h7777A5A5, 32'h0,        1'b0);
    txn("sh_32",   1'b1, 2'b01, 1'b0, 8'h32, 32'hCCCC8001, 32'h0,        1'b0);
    txn("lh_32",   1'b0, 2'b01, 1'b0, 8'h32, 32'h0,        32'hFFFF8001, 1'b0);
    txn("lhu_32",  1'b0, 2'b01, 1'b1, 8'h32, 32'h0,        32'h00008001, 1'b0);
    txn("lh_30",   1'b0, 2'b01, 1'b0, 8'h30, 32'h0,        32'hFFFFA5A5, 1'b0);
    txn("lw_30",   1'b0, 2'b10, 1'b0, 8'h30, 32'h0,        32'h8001A5A5, 1'b0);
    txn("mis_lw21",  1'b0, 2'b10, 1'b0, 8'h21, 32'h0,      32'h0,        1'b1);
    txn("mis_sh23",  1'b1, 2'b01, 1'b0, 8'h23, 32'hFFFFFFFF, 32'h0,      1'b1);
    txn("lw_20_post",1'b0, 2'b10, 1'b0, 8'h20, 32'h0,      32'h11AA3344, 1'b0);
    txn("mis_sz11",  1'b0, 2'b11, 1'b0, 8'h20, 32'h0,      32'h0,        1'b1);
    txn("mis_sz11w", 1'b1, 2'b11, 1'b0, 8'h24, 32'h0,      32'h0,        1'b1);
    txn("mis_lh11",  1'b0, 2'b01, 1'b1, 8'hFF, 32'h0,      32'h0,        1'b1);
    txn("sw_fc",   1'b1, 2'b10, 1'b0, 8'hFC, 32'hCAFEF00D, 32'h0,        1'b0);
    txn("lw_fc",   1'b0, 2'b10, 1'b0, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0);
    txn("lw_20_kept",1'b0, 2'b10, 1'b0, 8'h20, 32'h0,      32'h11AA3344, 1'b0);
    hold_test("hold_l2");

    // Latency sweep.
    for (int s = 0; s < 4; s++) begin
      if (s == 1) continue;
      sel = s;
      txn("sweep_sw", 1'b1, 2'b10, 1'b0, 8'h04, 32'hA5000000 | 32'(s), 32'h0, 1'b0);
      txn("sweep_lw", 1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 32'hA5000000 | 32'(s), 1'b0);
      txn("sweep_mis", 1'b0, 2'b10, 1'b0, 8'h06, 32'h0, 32'h0, 1'b1);
      hold_test("hold_sweep");
    end

    // Reset during the second WAIT cycle of a store, at LATENCY 4.
    sel = 2;
    txn("rst_sw_init", 1'b1, 2'b10, 1'b0, 8'h40, 32'h12345678, 32'h0, 1'b0);
    t_write = 1'b1; t_size = 2'b10; t_uns = 1'b0; t_addr = 8'h40; t_wdata = 32'h55555555;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    chk("rst/wait1_ready", 32'(m_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst/ready", 32'(m_ready), 32'd0);
    chk("rst/rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst/rdata", m_rsp_rdata, 32'd0);
    chk("rst/mis", 32'(m_mis), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst/hold_rsp_valid", 32'(m_rsp_valid), 32'd0);
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_rsp_valid) k++;
      @(negedge clk);
    end
    chk("rst/no_response", 32'(k), 32'd0);
    txn("rst_lw_after", 1'b0, 2'b10, 1'b0, 8'h40, 32'h0, 32'h12345678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
